tri_carrier_gen: RTL and testbench

Parametrised triangular/sawtooth carrier generator for the SPWM comparator stage of the VFD datapath. Successor to the fixed 12-bit up/down ramp: programmable width, peak, step and tick prescaler, plus a sawtooth mode. Peak/step/mode are double-buffered and take effect only at the valley, so carrier frequency changes never glitch. Peak and valley sync pulses let downstream sine-table and deadtime logic update at carrier boundaries.

---
 rtl/tri_carrier_gen.sv | 155 +++++++++++++++
 tb/tb_tri_carrier_gen.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_carrier_gen.sv
// Triangle/sawtooth PWM carrier with tick prescaler, valley-reloaded shadow settings and
// peak/valley sync pulses. Define TRI_COMPLEMENT_EN to add the phase-shifted wave_n output.
module tri_carrier_gen #(
   parameter int WIDTH    = 12,
   parameter int PRESC_W  = 8,
   parameter int RST_PEAK = 511
) (
   input  logic               clk_int,
   input  logic               rst,
   input  logic               en,
   input  logic [WIDTH-1:0]   peak_in,
   input  logic [WIDTH-1:0]   step_in,
   input  logic [PRESC_W-1:0] presc_in,
   input  logic               saw_mode_in,
   output logic [WIDTH-1:0]   wave,
   output logic               dir,
   output logic               peak_pulse,
   output logic               valley_pulse
`ifdef TRI_COMPLEMENT_EN
   ,
   output logic [WIDTH-1:0]   wave_n
`endif
);

   typedef enum logic {DIR_RISE = 1'b0, DIR_FALL = 1'b1} dir_t;

   dir_t               dir_q, dir_nx;
   logic [WIDTH-1:0]   wave_q, wave_nx;
   logic               peak_pulse_q, peak_pulse_nx;
   logic               valley_pulse_q, valley_pulse_nx;
   logic [PRESC_W-1:0] presc_cnt, presc_cnt_nx;
   logic [WIDTH-1:0]   peak_act, peak_nx;
   logic [WIDTH-1:0]   step_act, step_nx;
   logic [PRESC_W-1:0] presc_act, presc_nx;
   logic               saw_act, saw_nx;

   logic [WIDTH-1:0]   step_eff;
   logic [WIDTH:0]     sum_up;
   logic               tick;
   logic               reload;

   // A zero step would stall the carrier forever, so it behaves as a step of one.
   assign step_eff = (step_act == '0) ? WIDTH'(1) : step_act;
   assign sum_up   = {1'b0, wave_q} + {1'b0, step_eff};
   assign tick     = (presc_cnt == presc_act);

   always_comb begin
      wave_nx         = wave_q;
      dir_nx          = dir_q;
      peak_pulse_nx   = 1'b0;
      valley_pulse_nx = 1'b0;
      presc_cnt_nx    = presc_cnt;
      peak_nx         = peak_act;
      step_nx         = step_act;
      presc_nx        = presc_act;
      saw_nx          = saw_act;
      reload          = 1'b0;

      if (!en) begin
         presc_cnt_nx = '0;
      end else if (!tick) begin
         presc_cnt_nx = presc_cnt + PRESC_W'(1);
      end else begin
         presc_cnt_nx = '0;
         if (peak_act == '0) begin
            // Degenerate carrier: every tick is a valley so a new peak is picked up quickly.
            wave_nx         = '0;
            valley_pulse_nx = 1'b1;
            reload          = 1'b1;
         end else if (saw_act) begin
            if (wave_q == peak_act) begin
               wave_nx         = '0;
               valley_pulse_nx = 1'b1;
               reload          = 1'b1;
            end else if (sum_up >= {1'b0, peak_act}) begin
               wave_nx       = peak_act;
               peak_pulse_nx = 1'b1;
            end else begin
               wave_nx = sum_up[WIDTH-1:0];
            end
         end else if (dir_q == DIR_RISE) begin
            if (sum_up >= {1'b0, peak_act}) begin
               wave_nx       = peak_act;
               dir_nx        = DIR_FALL;
               peak_pulse_nx = 1'b1;
            end else begin
               wave_nx = sum_up[WIDTH-1:0];
            end
         end else begin
            if (wave_q <= step_eff) begin
               wave_nx         = '0;
               dir_nx          = DIR_RISE;
               valley_pulse_nx = 1'b1;
               reload          = 1'b1;
            end else begin
               wave_nx = wave_q - step_eff;
            end
         end
      end

      // Shadow settings become active only at the valley, keeping each period glitch-free.
      if (reload) begin
         peak_nx  = peak_in;
         step_nx  = step_in;
         presc_nx = presc_in;
         saw_nx   = saw_mode_in;
         dir_nx   = DIR_RISE;
      end
   end

   always_ff @(posedge clk_int) begin
      if (rst) begin
         wave_q         <= '0;
         dir_q          <= DIR_RISE;
         peak_pulse_q   <= 1'b0;
         valley_pulse_q <= 1'b0;
         presc_cnt      <= '0;
         peak_act       <= WIDTH'(RST_PEAK);
         step_act       <= WIDTH'(1);
         presc_act      <= '0;
         saw_act        <= 1'b0;
      end else begin
         wave_q         <= wave_nx;
         dir_q          <= dir_nx;
         peak_pulse_q   <= peak_pulse_nx;
         valley_pulse_q <= valley_pulse_nx;
         presc_cnt      <= presc_cnt_nx;
         peak_act       <= peak_nx;
         step_act       <= step_nx;
         presc_act      <= presc_nx;
         saw_act        <= saw_nx;
      end
   end

   assign wave         = wave_q;
   assign dir          = dir_q;
   assign peak_pulse   = peak_pulse_q;
   assign valley_pulse = valley_pulse_q;

`ifdef TRI_COMPLEMENT_EN
   logic [WIDTH-1:0] wave_n_q;

   // Built from next-state values so it stays aligned with wave, including across a reload.
   always_ff @(posedge clk_int) begin
      if (rst) begin
         wave_n_q <= WIDTH'(RST_PEAK);
      end else begin
         wave_n_q <= peak_nx - wave_nx;
      end
   end

   assign wave_n = wave_n_q;
`endif

endmodule

// File: tb/tb_tri_carrier_gen.sv
// Bench for tri_carrier_gen: directed vector table, hand-written en/reset sequences and
// randomized stimulus against a period-list reference model.
module tb_tri_carrier_gen;
   localparam int WIDTH    = 12;
   localparam int PRESC_W  = 8;
   localparam int RST_PEAK = 511;

   logic               clk_int = 1'b0;
   logic               rst;
   logic               en;
   logic [WIDTH-1:0]   peak_in;
   logic [WIDTH-1:0]   step_in;
   logic [PRESC_W-1:0] presc_in;
   logic               saw_mode_in;
   logic [WIDTH-1:0]   wave;
   logic               dir;
   logic               peak_pulse;
   logic               valley_pulse;
`ifdef TRI_COMPLEMENT_EN
   logic [WIDTH-1:0]   wave_n;
`endif

   tri_carrier_gen #(
      .WIDTH(WIDTH), .PRESC_W(PRESC_W), .RST_PEAK(RST_PEAK)
   ) dut (
      .clk_int(clk_int), .rst(rst), .en(en),
      .peak_in(peak_in), .step_in(step_in), .presc_in(presc_in), .saw_mode_in(saw_mode_in),
      .wave(wave), .dir(dir), .peak_pulse(peak_pulse), .valley_pulse(valley_pulse)
`ifdef TRI_COMPLEMENT_EN
      , .wave_n(wave_n)
`endif
   );

   // clock block
   always #5 clk_int = ~clk_int;

   // reference model: one list of per-tick outputs for the whole current period
   typedef struct {
      logic [WIDTH-1:0] wave;
      logic             dir;
      logic             pp;
      logic             vp;
   } exp_t;

   exp_t exp_q[$];
   int m_wave, m_dir, m_pp, m_vp, m_cnt;
   int m_peak, m_step, m_presc, m_saw;
   int n_checks = 0;
   int n_errors = 0;

   function automatic void push_exp(int w, int d, int p, int v);
      exp_t e;
      e.wave = WIDTH'(w);
      e.dir  = 1'(d);
      e.pp   = 1'(p);
      e.vp   = 1'(v);
      exp_q.push_back(e);
   endfunction

   function automatic void build_period(int peak, int step, int saw);
      int s;
      int v;
      exp_q.delete();
      s = (step == 0) ? 1 : step;
      if (peak == 0) begin
         push_exp(0, 0, 0, 1);
         return;
      end
      v = 0;
      while (v + s < peak) begin
         v = v + s;
         push_exp(v, 0, 0, 0);
      end
      push_exp(peak, (saw != 0) ? 0 : 1, 1, 0);
      if (saw == 0) begin
         v = peak;
         while (v > s) begin
            v = v - s;
            push_exp(v, 1, 0, 0);
         end
      end
      push_exp(0, 0, 0, 1);
   endfunction

   function automatic void model_step();
      exp_t e;
      if (rst) begin
         m_wave = 0; m_dir = 0; m_pp = 0; m_vp = 0; m_cnt = 0;
         m_peak = RST_PEAK; m_step = 1; m_presc = 0; m_saw = 0;
         build_period(m_peak, m_step, m_saw);
      end else if (!en) begin
         m_cnt = 0; m_pp = 0; m_vp = 0;
      end else if (m_cnt != m_presc) begin
         m_cnt = m_cnt + 1; m_pp = 0; m_vp = 0;
      end else begin
         m_cnt = 0;
         if (exp_q.size() == 0) build_period(m_peak, m_step, m_saw);
         e = exp_q.pop_front();
         m_wave = int'(e.wave); m_dir = int'(e.dir); m_pp = int'(e.pp); m_vp = int'(e.vp);
         if (e.vp) begin
            m_peak = int'(peak_in); m_step = int'(step_in);
            m_presc = int'(presc_in); m_saw = int'(saw_mode_in);
            build_period(m_peak, m_step, m_saw);
         end
      end
   endfunction

   // scoreboard
   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      check("model_wave", 32'(wave), 32'(m_wave));
      check("model_dir", 32'(dir), 32'(m_dir));
      check("model_peak_pulse", 32'(peak_pulse), 32'(m_pp));
      check("model_valley_pulse", 32'(valley_pulse), 32'(m_vp));
`ifdef TRI_COMPLEMENT_EN
      check("model_wave_n", 32'(wave_n), 32'(WIDTH'(m_peak - m_wave)));
`endif
   endtask

   // driver tasks
   task automatic drive(int pk, int st, int pr, int sw);
      peak_in     = WIDTH'(pk);
      step_in     = WIDTH'(st);
      presc_in    = PRESC_W'(pr);
      saw_mode_in = 1'(sw);
   endtask

   task automatic cycle();
      @(posedge clk_int);
      model_step();
      #1;
      compare_model();
   endtask

   task automatic wait_valley(int budget);
      logic found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         cycle();
         if (valley_pulse) found = 1'b1;
      end
      check("valley_within_budget", 32'(found), 32'd1);
   endtask

   typedef struct {
      int pk, st, pr, sw;
      int w, d, p, v;
   } vec_t;

   vec_t vec_q[$];

   function automatic void add_row(int pk, int st, int pr, int sw, int w, int d, int p, int v);
      vec_t r;
      r.pk = pk; r.st = st; r.pr = pr; r.sw = sw;
      r.w = w; r.d = d; r.p = p; r.v = v;
      vec_q.push_back(r);
   endfunction

   initial begin
      int peak_at;
      int valley_at;
      int peak_wave;
      int slow_w[17];
      logic hit;

      // vector table: starts on the tick after the first valley following reset
      add_row(10, 4, 0, 0,  4, 0, 0, 0);
      add_row(10, 4, 0, 0,  8, 0, 0, 0);
      add_row(10, 4, 0, 0, 10, 1, 1, 0);
      add_row(10, 4, 0, 0,  6, 1, 0, 0);
      add_row(10, 4, 0, 0,  2, 1, 0, 0);
      add_row( 5, 2, 0, 1,  0, 0, 0, 1);
      add_row( 5, 2, 0, 1,  2, 0, 0, 0);
      add_row( 5, 2, 0, 1,  4, 0, 0, 0);
      add_row( 5, 2, 0, 1,  5, 0, 1, 0);
      add_row( 3, 1, 2, 0,  0, 0, 0, 1);
      slow_w = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 2, 2, 2, 1, 1, 1};
      for (int k = 0; k < 17; k++)
         add_row(3, 1, 2, 0, slow_w[k], (k >= 8) ? 1 : 0, (k == 8) ? 1 : 0, 0);
      add_row( 0, 1, 0, 0,  0, 0, 0, 1);
      add_row( 0, 1, 0, 0,  0, 0, 0, 1);
      add_row( 3, 1, 0, 0,  0, 0, 0, 1);
      add_row( 3, 1, 0, 0,  1, 0, 0, 0);
      add_row( 3, 1, 0, 0,  2, 0, 0, 0);
      add_row( 3, 1, 0, 0,  3, 1, 1, 0);
      add_row( 3, 1, 0, 0,  2, 1, 0, 0);
      add_row( 3, 1, 0, 0,  1, 1, 0, 0);
      add_row( 3, 1, 0, 0,  0, 0, 0, 1);

      // reset state
      rst = 1'b1; en = 1'b1;
      drive(RST_PEAK, 1, 0, 0);
      cycle();
      cycle();
      check("reset_wave", 32'(wave), 32'd0);
      check("reset_dir", 32'(dir), 32'd0);
      check("reset_peak_pulse", 32'(peak_pulse), 32'd0);
      check("reset_valley_pulse", 32'(valley_pulse), 32'd0);
      rst = 1'b0;

      // default triangle period, with new settings staged mid-period
      peak_at = -1; valley_at = -1; peak_wave = -1;
      for (int i = 1; i <= 1100; i++) begin
         if (i == 300) drive(10, 4, 0, 0);
         cycle();
         if (peak_pulse) begin peak_at = i; peak_wave = int'(wave); end
         if (valley_pulse) begin valley_at = i; break; end
      end
      check("default_peak_cycle", 32'(peak_at), 32'd511);
      check("default_peak_value", 32'(peak_wave), 32'd511);
      check("default_period", 32'(valley_at), 32'd1022);

      // table-driven vectors
      for (int r = 0; r < vec_q.size(); r++) begin
         drive(vec_q[r].pk, vec_q[r].st, vec_q[r].pr, vec_q[r].sw);
         cycle();
         check($sformatf("vec%0d_wave", r), 32'(wave), 32'(vec_q[r].w));
         check($sformatf("vec%0d_dir", r), 32'(dir), 32'(vec_q[r].d));
         check($sformatf("vec%0d_peak_pulse", r), 32'(peak_pulse), 32'(vec_q[r].p));
         check($sformatf("vec%0d_valley_pulse", r), 32'(valley_pulse), 32'(vec_q[r].v));
      end

      // en dropped at wave 100 rising, prescaler must restart from zero
      drive(200, 1, 1, 0);
      wait_valley(100);
      hit = 1'b0;
      for (int i = 0; i < 400 && !hit; i++) begin
         cycle();
         if (wave == WIDTH'(100)) hit = 1'b1;
      end
      check("reach_wave_100", 32'(wave), 32'd100);
      cycle();
      en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         cycle();
         check("en_low_wave", 32'(wave), 32'd100);
         check("en_low_dir", 32'(dir), 32'd0);
         check("en_low_pulses", 32'({peak_pulse, valley_pulse}), 32'd0);
      end
      en = 1'b1;
      cycle();
      check("en_return_first", 32'(wave), 32'd100);
      cycle();
      check("en_return_second", 32'(wave), 32'd101);

      // reset asserted mid-descent
      hit = 1'b0;
      for (int i = 0; i < 800 && !hit; i++) begin
         cycle();
         if (dir && wave < WIDTH'(150)) hit = 1'b1;
      end
      check("descent_reached", 32'(dir), 32'd1);
      rst = 1'b1;
      drive(7, 3, 0, 0);
      cycle();
      check("midrst_wave", 32'(wave), 32'd0);
      check("midrst_dir", 32'(dir), 32'd0);
      check("midrst_pulses", 32'({peak_pulse, valley_pulse}), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 511; i++) cycle();
      check("midrst_peak_value", 32'(wave), 32'(RST_PEAK));
      check("midrst_peak_pulse", 32'(peak_pulse), 32'd1);

      // randomized stimulus against the model
      for (int i = 0; i < 4000; i++) begin
         drive(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 40)),
               int'($urandom_range(0, 9)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
         en  = ($urandom_range(0, 9) != 0);
         rst = ($urandom_range(0, 499) == 0);
         cycle();
      end
      rst = 1'b0;

      // final report
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion at %0t", $time);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
